// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-side bundle between the ID/EX datapath and the hazard/forwarding controller.
// The master is the pipeline (drives ID decode fields); the slave is the controller.
interface hazard_fwd_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_is_load;
    logic                  id_a_is_pc;
    logic                  id_b_is_imm;
    logic                  ex_br_taken;

    logic [1:0]            alu_a_sel;
    logic [1:0]            alu_b_sel;
    logic [1:0]            st_data_sel;
    logic                  stall_if;
    logic                  stall_id;
    logic                  bubble_ex;
    logic                  flush_id;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
               id_is_load, id_a_is_pc, id_b_is_imm, ex_br_taken,
        input  alu_a_sel, alu_b_sel, st_data_sel, stall_if, stall_id, bubble_ex, flush_id,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
               id_is_load, id_a_is_pc, id_b_is_imm, ex_br_taken,
        output alu_a_sel, alu_b_sel, st_data_sel, stall_if, stall_id, bubble_ex, flush_id,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 5-stage core: shadows EX/MEM destinations, produces registered
// EX operand selects, stall/bubble/flush controls and saturating stall/flush event counters.
module hazard_fwd_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32,
    parameter bit          FWD_EN     = 1'b1
) (
    input logic               clock,
    input logic               reset,
    hazard_fwd_ctrl_if.slave  hz
);
    localparam logic [1:0] SelReg = 2'b00;
    localparam logic [1:0] SelAlt = 2'b01;
    localparam logic [1:0] SelMem = 2'b10;
    localparam logic [1:0] SelWb  = 2'b11;

    logic                  ex_v_q,  ex_v_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_we_q, ex_we_d;
    logic                  ex_ld_q, ex_ld_d;
    logic                  mem_v_q,  mem_v_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_we_q, mem_we_d;

    logic [1:0]            a_sel_q,  a_sel_d;
    logic [1:0]            b_sel_q,  b_sel_d;
    logic [1:0]            st_sel_q, st_sel_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
    logic load_use;
    logic bubble_int;
    logic stall_if, stall_id, bubble_ex, flush_id;

    always_comb begin
        ex_hit_rs1  = hz.id_use_rs1 && (hz.id_rs1 != '0) && ex_v_q && ex_we_q &&
                      (ex_rd_q == hz.id_rs1);
        ex_hit_rs2  = hz.id_use_rs2 && (hz.id_rs2 != '0) && ex_v_q && ex_we_q &&
                      (ex_rd_q == hz.id_rs2);
        mem_hit_rs1 = hz.id_use_rs1 && (hz.id_rs1 != '0) && mem_v_q && mem_we_q &&
                      (mem_rd_q == hz.id_rs1);
        mem_hit_rs2 = hz.id_use_rs2 && (hz.id_rs2 != '0) && mem_v_q && mem_we_q &&
                      (mem_rd_q == hz.id_rs2);

        if (FWD_EN) begin
            load_use = (ex_hit_rs1 || ex_hit_rs2) && ex_ld_q;
        end else begin
            load_use = ex_hit_rs1 || ex_hit_rs2 || mem_hit_rs1 || mem_hit_rs2;
        end
    end

    // A taken branch squashes the stalled instruction anyway, so flush overrides the stall.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (!reset) begin
            if (hz.ex_br_taken) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
        bubble_int = hz.ex_br_taken || load_use;
    end

    always_comb begin
        ex_v_d   = hz.id_valid && !bubble_int;
        ex_rd_d  = hz.id_rd;
        ex_we_d  = hz.id_regwrite;
        ex_ld_d  = hz.id_is_load;
        mem_v_d  = ex_v_q;
        mem_rd_d = ex_rd_q;
        mem_we_d = ex_we_q;
    end

    // Selects follow the instruction into EX; an EX hit is newer than a MEM hit.
    always_comb begin
        a_sel_d  = SelReg;
        b_sel_d  = SelReg;
        st_sel_d = SelReg;
        if (hz.id_valid && !bubble_int) begin
            if (FWD_EN) begin
                if (ex_hit_rs1 && !ex_ld_q) begin
                    a_sel_d = SelMem;
                end else if (mem_hit_rs1) begin
                    a_sel_d = SelWb;
                end
                if (ex_hit_rs2 && !ex_ld_q) begin
                    b_sel_d  = SelMem;
                    st_sel_d = SelMem;
                end else if (mem_hit_rs2) begin
                    b_sel_d  = SelWb;
                    st_sel_d = SelWb;
                end
            end
            if (hz.id_a_is_pc) begin
                a_sel_d = SelAlt;
            end
            if (hz.id_b_is_imm) begin
                b_sel_d = SelAlt;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_id && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_id && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_v_q      <= 1'b0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            a_sel_q     <= SelReg;
            b_sel_q     <= SelReg;
            st_sel_q    <= SelReg;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_ld_q     <= ex_ld_d;
            mem_v_q     <= mem_v_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            st_sel_q    <= st_sel_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.alu_a_sel   = a_sel_q;
    assign hz.alu_b_sel   = b_sel_q;
    assign hz.st_data_sel = st_sel_q;
    assign hz.stall_if    = stall_if;
    assign hz.stall_id    = stall_id;
    assign hz.bubble_ex   = bubble_ex;
    assign hz.flush_id    = flush_id;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule
